// File: rtl/fifo_message_pkg.sv
// -----------------------------------------------------------------------------
// fifo_message_pkg
// Shared types and constants for the NoC response/message record FIFO.
//   msg_t      : one five-byte record {header, dest ID, source ID, addr, data}
//   CMD_*      : header command codes (bits [2:0] of al_dl); only the consumer
//                interprets them, the FIFO stores records opaquely.
// -----------------------------------------------------------------------------
package fifo_message_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned MSG_W  = 5 * BYTE_W;

    // Header byte layout: {Alen[7:6], Dlen[5:3], cmd[2:0]}
    localparam logic [2:0] CMD_IDLE       = 3'd0;
    localparam logic [2:0] CMD_READ       = 3'd1;
    localparam logic [2:0] CMD_WRITE      = 3'd2;
    localparam logic [2:0] CMD_READ_RESP  = 3'd3;
    localparam logic [2:0] CMD_WRITE_RESP = 3'd4;
    localparam logic [2:0] CMD_MESSAGE    = 3'd5;

    typedef struct packed {
        logic [BYTE_W-1:0] al_dl;
        logic [BYTE_W-1:0] d_id;
        logic [BYTE_W-1:0] s_id;
        logic [BYTE_W-1:0] m_addr;
        logic [BYTE_W-1:0] m_data;
    } msg_t;

endpackage : fifo_message_pkg

// File: rtl/fifo_message.sv
// -----------------------------------------------------------------------------
// fifo_message
// Show-ahead FIFO of five-byte NoC response/message records, sitting between
// the request-side logic (producer) and the frm_data serializer (consumer).
//
// Parameters
//   DEPTH : number of record entries (power of two, >= 2)
//   AW    : pointer width, $clog2(DEPTH)
//
// Ports
//   clk, reset        : clock, asynchronous active-low reset
//   Al_Dlin .. M_Datain : record bytes pushed when writep is accepted
//   writep, readp     : push / pop requests
//   Al_Dl .. M_Dataout  : head record, combinational; 8'h00 while empty
//   emptyp, fullp     : occupancy flags decoded from the registered count
//
// Optional build macro
//   FIFO_MESSAGE_ASSERT_EN : compiles in simulation-only overflow/underflow
//                            and count-range checks. No effect on hardware.
// -----------------------------------------------------------------------------
module fifo_message
    import fifo_message_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] Al_Dlin,
    input  logic [BYTE_W-1:0] D_IDin,
    input  logic [BYTE_W-1:0] S_IDin,
    input  logic [BYTE_W-1:0] M_Addrin,
    input  logic [BYTE_W-1:0] M_Datain,
    input  logic              writep,
    input  logic              readp,
    output logic [BYTE_W-1:0] Al_Dl,
    output logic [BYTE_W-1:0] D_IDout,
    output logic [BYTE_W-1:0] S_IDout,
    output logic [BYTE_W-1:0] M_Addrout,
    output logic [BYTE_W-1:0] M_Dataout,
    output logic              emptyp,
    output logic              fullp
);

    localparam int unsigned CW = AW + 1;

    msg_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          push_ok;
    logic          pop_ok;
    msg_t          wr_rec;
    msg_t          head;

    // Flags come only from the registered count, never from writep/readp.
    assign emptyp = (count == '0);
    assign fullp  = (count == CW'(DEPTH));

    // A push while full is admitted only because the same-cycle pop frees
    // the head slot; a pop while empty is simply dropped.
    assign push_ok = writep && (!fullp || readp);
    assign pop_ok  = readp && !emptyp;

    assign wr_rec = '{al_dl:  Al_Dlin,
                      d_id:   D_IDin,
                      s_id:   S_IDin,
                      m_addr: M_Addrin,
                      m_data: M_Datain};

    // Record storage; not reset, empty gating hides stale contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_rec;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Show-ahead head, forced to zero while empty.
    always_comb begin
        head = '0;
        if (!emptyp) begin
            head = mem[rd_ptr];
        end
    end

    assign Al_Dl     = head.al_dl;
    assign D_IDout   = head.d_id;
    assign S_IDout   = head.s_id;
    assign M_Addrout = head.m_addr;
    assign M_Dataout = head.m_data;

`ifdef FIFO_MESSAGE_ASSERT_EN
    // Simulation-only protocol checks.
    always @(posedge clk) begin
        if (reset) begin
            if (writep && fullp && !readp) begin
                $error("fifo_message: overflow, push while full dropped");
            end
            if (readp && emptyp) begin
                $error("fifo_message: underflow, pop while empty ignored");
            end
            if (count > CW'(DEPTH)) begin
                $error("fifo_message: count %0d exceeds DEPTH %0d", count, DEPTH);
            end
        end
    end
`endif

endmodule : fifo_message

// File: tb/tb_fifo_message.sv
module tb_fifo_message;
    import fifo_message_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic       clk;
    logic       reset;
    logic [7:0] Al_Dlin, D_IDin, S_IDin, M_Addrin, M_Datain;
    logic       writep, readp;
    logic [7:0] Al_Dl, D_IDout, S_IDout, M_Addrout, M_Dataout;
    logic       emptyp, fullp;

    int nchk = 0;
    int nerr = 0;

    fifo_message #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .Al_Dlin   (Al_Dlin),
        .D_IDin    (D_IDin),
        .S_IDin    (S_IDin),
        .M_Addrin  (M_Addrin),
        .M_Datain  (M_Datain),
        .writep    (writep),
        .readp     (readp),
        .Al_Dl     (Al_Dl),
        .D_IDout   (D_IDout),
        .S_IDout   (S_IDout),
        .M_Addrout (M_Addrout),
        .M_Dataout (M_Dataout),
        .emptyp    (emptyp),
        .fullp     (fullp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic msg_t head();
        return {Al_Dl, D_IDout, S_IDout, M_Addrout, M_Dataout};
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock with the given requests; returns 1ns after the edge.
    task automatic cycle(input logic w, input logic r, input msg_t d);
        writep = w;
        readp  = r;
        {Al_Dlin, D_IDin, S_IDin, M_Addrin, M_Datain} = d;
        @(posedge clk);
        #1;
        writep = 1'b0;
        readp  = 1'b0;
    endtask

    function automatic msg_t mk(input logic [7:0] data);
        return {CMD_READ_RESP, 5'b0, 8'h10, 8'h20} << 16 | {16'h0, data, data};
    endfunction

    msg_t q[$];
    msg_t rec;
    msg_t zero_rec;

    initial begin
        zero_rec = '0;
        reset = 1'b1;
        writep = 1'b0; readp = 1'b0;
        Al_Dlin = '0; D_IDin = '0; S_IDin = '0; M_Addrin = '0; M_Datain = '0;

        // Reset and idle
        #2 reset = 1'b0;
        #1;
        chk("rst_empty", 40'(emptyp), 40'(1));
        chk("rst_full",  40'(fullp),  40'(0));
        chk("rst_head",  head(),      40'h0);
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b0, 1'b0, zero_rec);
        cycle(1'b0, 1'b0, zero_rec);
        chk("idle_empty", 40'(emptyp), 40'(1));
        chk("idle_full",  40'(fullp),  40'(0));
        chk("idle_head",  head(),      40'h0);

        // Single record
        rec = {8'h04, 8'h12, 8'h34, 8'h08, 8'h07};
        cycle(1'b1, 1'b0, rec);
        chk("single_head",  head(),      40'h0412340807);
        chk("single_empty", 40'(emptyp), 40'(0));
        cycle(1'b0, 1'b1, zero_rec);
        chk("single_pop_head",  head(),      40'h0);
        chk("single_pop_empty", 40'(emptyp), 40'(1));

        // Fill, overflow drop, ordered drain
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, mk(8'(i)));
        chk("fill_full",  40'(fullp),  40'(1));
        chk("fill_empty", 40'(emptyp), 40'(0));
        chk("fill_head",  head(),      40'h6010200000);
        cycle(1'b1, 1'b0, mk(8'hEE));
        chk("ovf_full", 40'(fullp),     40'(1));
        chk("ovf_head", 40'(M_Dataout), 40'h00);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_%0d", i), 40'(M_Dataout), 40'(i));
            cycle(1'b0, 1'b1, zero_rec);
        end
        chk("drain_empty", 40'(emptyp), 40'(1));
        chk("drain_head",  head(),      40'h0);

        // Push and pop together while full
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, mk(8'(i)));
        chk("full_rw_pre", 40'(M_Dataout), 40'h00);
        cycle(1'b1, 1'b1, mk(8'hAA));
        chk("full_rw_full", 40'(fullp),     40'(1));
        chk("full_rw_head", 40'(M_Dataout), 40'h01);
        for (int i = 1; i < 17; i++) begin
            chk($sformatf("full_rw_drain_%0d", i), 40'(M_Dataout),
                (i == 16) ? 40'hAA : 40'(i));
            cycle(1'b0, 1'b1, zero_rec);
        end
        chk("full_rw_empty", 40'(emptyp), 40'(1));

        // Push and pop together while empty: only the push lands
        cycle(1'b1, 1'b1, mk(8'h55));
        chk("empty_rw_empty", 40'(emptyp), 40'(0));
        chk("empty_rw_full",  40'(fullp),  40'(0));
        chk("empty_rw_head",  head(),      40'h6010205555);
        cycle(1'b0, 1'b1, zero_rec);
        chk("empty_rw_pop", 40'(emptyp), 40'(1));

        // Random interleave across pointer wrap against a reference queue
        for (int i = 0; i < 40; i++) begin
            logic w, r;
            msg_t d;
            w = ($urandom_range(0, 99) < 60);
            r = ($urandom_range(0, 99) < 50);
            d = {$urandom(), 8'($urandom())};
            if (r && q.size() > 0) begin
                chk($sformatf("wrap_head_%0d", i), head(), q[0]);
            end
            if (r && q.size() > 0) void'(q.pop_front());
            if (w && (q.size() < DEPTH || r)) q.push_back(d);
            cycle(w, r, d);
            chk($sformatf("wrap_empty_%0d", i), 40'(emptyp), 40'(q.size() == 0));
            chk($sformatf("wrap_full_%0d", i),  40'(fullp),  40'(q.size() == DEPTH));
        end
        while (q.size() > 0) begin
            chk("wrap_drain", head(), q.pop_front());
            cycle(1'b0, 1'b1, zero_rec);
        end
        chk("wrap_final_empty", 40'(emptyp), 40'(1));

        // Asynchronous reset with 5 queued records, between edges
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, mk(8'(8'h30 + i)));
        chk("pre_rst_head", 40'(M_Dataout), 40'h30);
        #2 reset = 1'b0;
        #1;
        chk("arst_empty", 40'(emptyp), 40'(1));
        chk("arst_full",  40'(fullp),  40'(0));
        chk("arst_head",  head(),      40'h0);
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b0, 1'b0, zero_rec);
        chk("post_rst_empty", 40'(emptyp), 40'(1));
        chk("post_rst_head",  head(),      40'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule : tb_fifo_message
